mac_acc_drain: RTL and testbench

Downstream stage of the MAC accumulator block. It counts enabled accumulation beats, snapshots the four accumulator lanes after a programmable number of beats, and pulses a clear back to the accumulators. It then streams the snapshot as four 32-bit words over a valid/ready interface, marking result boundaries according to the single, dual or quad lane mode.

---
 rtl/mac_acc_drain.sv | 225 ++++++++++++++++++++++
 tb/tb_mac_acc_drain.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_drain.sv
// rtl/mac_acc_drain.sv - beat counter, snapshot capture and 4-word drain stream for the MAC accumulator
//
// Counts enabled accumulation beats and pulses acc_clr_o after acc_len_i beats.
// On the edge that ends the acc_clr_o cycle it snapshots the four accumulator
// lanes and the lane mode. It then streams the snapshot as four words, in0
// first, with out_last_o marking result boundaries for the stored mode.
//
// Optional feature macro: MAC_DRAIN_SKID_EN
//   defined   : a one-deep pending snapshot absorbs a capture that arrives while
//               streaming; a capture with both buffers full is dropped.
//   undefined : any capture while streaming is dropped.
//   A drop sets the sticky overrun_o flag.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   en_i         accumulate enable (same signal as the accumulator block)
//   cfg_mode_i   lane mode (single/dual/quad), sampled at capture
//   acc_len_i    beats per window; 0 disables capture
//   in0_i..in3_i accumulator lanes, in0_i least significant
//   acc_clr_o    one-cycle accumulator clear pulse
//   out_data_o   stream word
//   out_valid_o  stream valid
//   out_ready_i  stream ready
//   out_last_o   last word of a result
//   ovr_clr_i    clears overrun_o
//   overrun_o    sticky: a snapshot was dropped

module mac_acc_drain #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [1:0]               cfg_mode_i,
  input  logic [CNT_WIDTH-1:0]     acc_len_i,
  input  logic [MAC_ACC_WIDTH-1:0] in0_i,
  input  logic [MAC_ACC_WIDTH-1:0] in1_i,
  input  logic [MAC_ACC_WIDTH-1:0] in2_i,
  input  logic [MAC_ACC_WIDTH-1:0] in3_i,
  output logic                     acc_clr_o,
  output logic [MAC_ACC_WIDTH-1:0] out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_last_o,
  input  logic                     ovr_clr_i,
  output logic                     overrun_o
);

  // Lane-mode encodings shared with the accumulator block (mac_const.vh).
  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;
  typedef logic [3:0][MAC_ACC_WIDTH-1:0] lanes_t;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 acc_clr_q, acc_clr_d;
  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  lanes_t               act_q, act_d;
  logic [1:0]           act_mode_q, act_mode_d;
  logic                 overrun_q, overrun_d;
`ifdef MAC_DRAIN_SKID_EN
  lanes_t               pend_q, pend_d;
  logic [1:0]           pend_mode_q, pend_mode_d;
  logic                 pend_vld_q, pend_vld_d;
`endif

  lanes_t snap;
  logic   capture;
  logic   fire;
  logic   done;
  logic   drop;

  assign snap    = {in3_i, in2_i, in1_i, in0_i};
  // The clear cycle is also the capture cycle: the accumulators still hold the
  // completed window on the edge that ends it.
  assign capture = acc_clr_q;
  assign fire    = (state_q == ST_SEND) && out_ready_i;
  assign done    = fire && (idx_q == 2'd3);

  // Beat counter. A beat that coincides with the clear is lost by the
  // accumulators, so it is not counted here either.
  always_comb begin
    cnt_d     = cnt_q;
    acc_clr_d = 1'b0;
    if (acc_len_i == '0) begin
      cnt_d = '0;
    end else if (en_i && !acc_clr_q) begin
      // >= keeps the counter bounded if acc_len shrinks mid-window.
      if (cnt_q >= acc_len_i - 1'b1) begin
        cnt_d     = '0;
        acc_clr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Drain FSM next state. A buffer freed by the final word on this edge is
  // reusable on the same edge, so a capture then is never dropped.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    act_d      = act_q;
    act_mode_d = act_mode_q;
    drop       = 1'b0;
`ifdef MAC_DRAIN_SKID_EN
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    pend_vld_d  = pend_vld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          act_d      = snap;
          act_mode_d = cfg_mode_i;
          idx_d      = 2'd0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // Two-bit index wraps to word 0 when word 3 is accepted.
        if (fire) idx_d = idx_q + 2'd1;
        if (done) begin
`ifdef MAC_DRAIN_SKID_EN
          if (pend_vld_q) begin
            act_d      = pend_q;
            act_mode_d = pend_mode_q;
            pend_vld_d = 1'b0;
            if (capture) begin
              pend_d      = snap;
              pend_mode_d = cfg_mode_i;
              pend_vld_d  = 1'b1;
            end
          end else if (capture) begin
            act_d      = snap;
            act_mode_d = cfg_mode_i;
          end else begin
            state_d = ST_IDLE;
          end
`else
          if (capture) begin
            act_d      = snap;
            act_mode_d = cfg_mode_i;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end else if (capture) begin
`ifdef MAC_DRAIN_SKID_EN
          if (pend_vld_q) begin
            drop = 1'b1;
          end else begin
            pend_d      = snap;
            pend_mode_d = cfg_mode_i;
            pend_vld_d  = 1'b1;
          end
`else
          drop = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A drop on the same edge as a clear request keeps the flag set.
    overrun_d = drop | (overrun_q & ~ovr_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      acc_clr_q  <= 1'b0;
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      act_q      <= '0;
      act_mode_q <= 2'd0;
      overrun_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_clr_q  <= acc_clr_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      act_mode_q <= act_mode_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef MAC_DRAIN_SKID_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q      <= '0;
      pend_mode_q <= 2'd0;
      pend_vld_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      pend_vld_q  <= pend_vld_d;
    end
  end
`endif

  // Data and last are forced to 0 outside SEND so the stream is quiet when idle.
  always_comb begin
    out_valid_o = (state_q == ST_SEND);
    out_data_o  = '0;
    out_last_o  = 1'b0;
    if (out_valid_o) begin
      out_data_o = act_q[idx_q];
      case (act_mode_q)
        MAC_SINGLE: out_last_o = 1'b1;
        MAC_DUAL:   out_last_o = idx_q[0];
        default:    out_last_o = (idx_q == 2'd3);
      endcase
    end
  end

  assign acc_clr_o = acc_clr_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_mac_acc_drain.sv
// tb/tb_mac_acc_drain.sv - self-checking bench for mac_acc_drain against a queue-based reference model

module tb_mac_acc_drain;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_DUAL   = 2'd1;
  localparam logic [1:0] M_QUAD   = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] acc_len;
  logic [W-1:0]  in0, in1, in2, in3;
  logic          acc_clr;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          ovr_clr;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  mac_acc_drain dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_mode_i(cfg_mode),
    .acc_len_i(acc_len), .in0_i(in0), .in1_i(in1), .in2_i(in2), .in3_i(in3),
    .acc_clr_o(acc_clr), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_last_o(out_last), .ovr_clr_i(ovr_clr),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  logic [35:0] dut_vec;
  assign dut_vec = {acc_clr, out_valid, out_last, overrun, out_data};

  // Reference model: results waiting or in flight are a queue of snapshots,
  // the head being streamed word by word; capacity 1 or 2 snapshots.
  typedef struct packed {
    logic [1:0]        mode;
    logic [3:0][W-1:0] w;
  } snap_t;

  snap_t m_q[$];
  int    m_beats;
  bit    m_clr;
  int    m_widx;
  bit    m_ovr;
  int    m_cap;

  function automatic void model_reset();
    m_q.delete();
    m_beats = 0;
    m_clr   = 1'b0;
    m_widx  = 0;
    m_ovr   = 1'b0;
  endfunction

  task automatic model_edge();
    bit    drop = 1'b0;
    snap_t s;
    if (m_q.size() > 0 && out_ready) begin
      m_widx++;
      if (m_widx == 4) begin
        m_widx = 0;
        void'(m_q.pop_front());
      end
    end
    if (m_clr) begin
      s.mode = cfg_mode;
      s.w    = {in3, in2, in1, in0};
      if (m_q.size() < m_cap) m_q.push_back(s);
      else drop = 1'b1;
    end
    m_ovr = drop || (m_ovr && !ovr_clr);
    if (acc_len == 0) begin
      m_beats = 0;
      m_clr   = 1'b0;
    end else if (en && !m_clr) begin
      m_beats++;
      m_clr = (m_beats == int'(acc_len));
      if (m_clr) m_beats = 0;
    end else begin
      m_clr = 1'b0;
    end
  endtask

  function automatic logic [35:0] exp_vec();
    logic last;
    if (m_q.size() == 0) return {m_clr, 1'b0, 1'b0, m_ovr, 32'h0};
    case (m_q[0].mode)
      M_SINGLE: last = 1'b1;
      M_DUAL:   last = (m_widx == 1) || (m_widx == 3);
      default:  last = (m_widx == 3);
    endcase
    return {m_clr, 1'b1, last, m_ovr, m_q[0].w[m_widx]};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    ovr_clr   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_lanes();
    in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; ovr_clr = 1'b0;
    cfg_mode = M_QUAD; acc_len = 16'd1; rand_lanes();
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== 36'h0) begin
      errors++; $display("FAIL reset_outputs got %h want %h", dut_vec, 36'h0);
    end
    en = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic_quad();
    logic [W-1:0] seen[$];
    logic [3:0][W-1:0] want;
    int nclr = 0, nlast = 0;
    do_reset();
    acc_len = 16'd3; cfg_mode = M_QUAD; out_ready = 1'b1;
    in0 = 32'h11111111; in1 = 32'h22222222; in2 = 32'h33333333; in3 = 32'h44444444;
    want = {in3, in2, in1, in0};
    for (int c = 0; c < 14; c++) begin
      en = (c < 3);
      if (out_valid && out_ready) begin
        seen.push_back(out_data);
        if (out_last) nlast++;
      end
      tick();
      if (acc_clr) nclr++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL quad_cycle%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (nclr != 1) begin errors++; $display("FAIL quad_clr_pulses got %0d want 1", nclr); end
    checks++;
    if (nlast != 1) begin errors++; $display("FAIL quad_last_count got %0d want 1", nlast); end
    checks++;
    if (seen.size() != 4) begin
      errors++; $display("FAIL quad_word_count got %0d want 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== want[i]) begin
          errors++; $display("FAIL quad_word%0d got %h want %h", i, seen[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_dual_backpressure();
    int nxfer = 0, nlast = 0;
    do_reset();
    acc_len = 16'd2; cfg_mode = M_DUAL; rand_lanes();
    for (int c = 0; c < 20; c++) begin
      en = (c < 2);
      out_ready = (c % 2 == 1);
      if (out_valid && out_ready) begin
        nxfer++;
        if (out_last) nlast++;
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL dual_cycle%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (nxfer != 4) begin errors++; $display("FAIL dual_transfers got %0d want 4", nxfer); end
    checks++;
    if (nlast != 2) begin errors++; $display("FAIL dual_last_count got %0d want 2", nlast); end
  endtask

  task automatic test_gating();
    logic [4:0] pat = 5'b11011;
    int first_clr = -1, nclr = 0, nvld = 0;
    do_reset();
    acc_len = 16'd4; cfg_mode = M_QUAD; out_ready = 1'b1; rand_lanes();
    for (int c = 0; c < 12; c++) begin
      en = (c < 5) ? pat[c] : 1'b0;
      tick();
      if (acc_clr && first_clr < 0) first_clr = c;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL gate_cycle%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (first_clr != 4) begin errors++; $display("FAIL gate_clr_cycle got %0d want 4", first_clr); end
    do_reset();
    acc_len = 16'd0; out_ready = 1'b1; en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (acc_clr) nclr++;
      if (out_valid) nvld++;
    end
    checks++;
    if (nclr != 0) begin errors++; $display("FAIL len0_clr got %0d want 0", nclr); end
    checks++;
    if (nvld != 0) begin errors++; $display("FAIL len0_valid got %0d want 0", nvld); end
  endtask

  task automatic test_overrun();
    int nclr = 0, ovr_at = -1, nxfer = 0;
    do_reset();
    acc_len = 16'd2; cfg_mode = M_QUAD; en = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      rand_lanes();
      tick();
      if (overrun && ovr_at < 0) ovr_at = nclr;
      if (acc_clr) nclr++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ovr_fill%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (ovr_at != m_cap + 1) begin
      errors++; $display("FAIL ovr_capture_index got %0d want %0d", ovr_at, m_cap + 1);
    end
    en = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (out_valid && out_ready) nxfer++;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL ovr_drain%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (nxfer != 4 * m_cap) begin
      errors++; $display("FAIL ovr_transfers got %0d want %0d", nxfer, 4 * m_cap);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] seen[$];
    logic [W-1:0] w0, w3;
    bit hit = 1'b0;
    do_reset();
    acc_len = 16'd3; cfg_mode = M_QUAD; out_ready = 1'b1; rand_lanes();
    for (int c = 0; c < 20 && !hit; c++) begin
      en = (c < 3);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL mid_pre%0d got %h want %h", c, dut_vec, exp_vec());
      end
      if (m_q.size() > 0 && m_widx == 2) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_word1_timeout got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 36'h0) begin
      errors++; $display("FAIL mid_async_zero got %h want %h", dut_vec, 36'h0);
    end
    model_reset();
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_lanes();
    w0 = in0; w3 = in3;
    for (int c = 0; c < 14; c++) begin
      en = (c < 3);
      if (out_valid && out_ready) seen.push_back(out_data);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL mid_post%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (seen.size() != 4) begin
      errors++; $display("FAIL mid_word_count got %0d want 4", seen.size());
    end else begin
      checks++;
      if (seen[0] !== w0 || seen[3] !== w3) begin
        errors++; $display("FAIL mid_words got %h/%h want %h/%h", seen[0], seen[3], w0, w3);
      end
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      acc_len = 16'($urandom_range(1, 6));
      for (int c = 0; c < 400; c++) begin
        en        = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        ovr_clr   = ($urandom_range(0, 7) == 0);
        cfg_mode  = 2'($urandom_range(0, 2));
        rand_lanes();
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL rand_seg%0d_cycle%0d got %h want %h", seg, c, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
`ifdef MAC_DRAIN_SKID_EN
    m_cap = 2;
`else
    m_cap = 1;
`endif
    rst_n = 1'b0; en = 1'b0; cfg_mode = M_QUAD; acc_len = '0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0; out_ready = 1'b0; ovr_clr = 1'b0;
    test_reset();
    test_basic_quad();
    test_dual_backpressure();
    test_gating();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
